// File: rtl/regsel_pkg.sv
// regsel_pkg: sequencer state encoding, source-select constant and default widths for regsel_seq.
package regsel_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  localparam int SRC_USEQ     = 0;
  localparam int DEF_SEL_W    = 3;
  localparam int DEF_NREGS    = 8;
  localparam int DEF_N_OPS    = 3;
  localparam int DEF_LOAD_CYC = 1;
  localparam int DEF_SRC_W    = 2;
endpackage

// File: rtl/regsel_seq_decode.sv
// regsel_decode: enable + register index to active-low one-hot, flagging indices past NREGS.
module regsel_decode
  import regsel_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic             i_en,
  input  logic [SEL_W-1:0] i_idx,
  output logic [NREGS-1:0] o_vec_n,
  output logic             o_oor
);
  assign o_oor   = i_en && (32'(i_idx) >= NREGS);
  assign o_vec_n = (i_en && !o_oor) ? ~(NREGS'(1) << i_idx) : '1;
endmodule

// File: rtl/regsel_seq.sv
// regsel_seq: sequenced register-transfer strobe generator (SETUP/STROBE/HOLD, active-low one-hot).
// Optional REGSEL_HAZARD_EN: flag same-register OE+load and drop OE while the load strobe is low.
module regsel_seq
  import regsel_pkg::*;
#(
  parameter int SEL_W    = DEF_SEL_W,
  parameter int NREGS    = DEF_NREGS,
  parameter int N_OPS    = DEF_N_OPS,
  parameter int LOAD_CYC = DEF_LOAD_CYC,
  parameter int SRC_W    = DEF_SRC_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   ready,
  input  logic                   oe,
  input  logic                   load,
  input  logic [SRC_W-1:0]       oeSourceSel,
  input  logic [SRC_W-1:0]       loadSourceSel,
  input  logic [SEL_W-1:0]       useqRegSelOE,
  input  logic [SEL_W-1:0]       useqRegSelLoad,
  input  logic [N_OPS*SEL_W-1:0] ops,
  output logic [NREGS-1:0]       regNotOEs,
  output logic [NREGS-1:0]       regNotLoads,
  output logic                   done,
  output logic                   selError,
  output logic                   hazard
);
  localparam int CNT_W = LOAD_CYC > 1 ? $clog2(LOAD_CYC) : 1;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] w_oe_idx, w_ld_idx;
  logic [NREGS-1:0] w_oe_dec, w_ld_dec, w_oe_sel, w_ld_sel, r_oe_vec, r_ld_vec, r_oes, r_lds;
  logic w_oe_src_ok, w_ld_src_ok, w_oe_oor, w_ld_oor, w_accept, w_haz_new, w_haz_sel;
  logic r_load, r_haz, r_err, r_done, r_ready;
  always_comb begin
    w_oe_idx = useqRegSelOE;
    w_ld_idx = useqRegSelLoad;
    for (int k = 0; k < N_OPS; k++) begin
      if (oeSourceSel == SRC_W'(SRC_USEQ + k + 1)) w_oe_idx = ops[k*SEL_W +: SEL_W];
      if (loadSourceSel == SRC_W'(SRC_USEQ + k + 1)) w_ld_idx = ops[k*SEL_W +: SEL_W];
    end
  end
  assign w_oe_src_ok = 32'(oeSourceSel) <= N_OPS;
  assign w_ld_src_ok = 32'(loadSourceSel) <= N_OPS;
  regsel_decode #(.NREGS(NREGS), .SEL_W(SEL_W)) u_oe_dec (
    .i_en(oe && w_oe_src_ok), .i_idx(w_oe_idx), .o_vec_n(w_oe_dec), .o_oor(w_oe_oor)
  );
  regsel_decode #(.NREGS(NREGS), .SEL_W(SEL_W)) u_ld_dec (
    .i_en(load && w_ld_src_ok), .i_idx(w_ld_idx), .o_vec_n(w_ld_dec), .o_oor(w_ld_oor)
  );
`ifdef REGSEL_HAZARD_EN
  // Both decodes low on the same bit means a valid OE and load of one register.
  assign w_haz_new = (w_oe_dec == w_ld_dec) && !(&w_oe_dec);
`else
  assign w_haz_new = 1'b0;
`endif
  assign w_accept  = start && r_state == IDLE;
  assign w_oe_sel  = w_accept ? w_oe_dec : r_oe_vec;
  assign w_ld_sel  = w_accept ? w_ld_dec : r_ld_vec;
  assign w_haz_sel = w_accept ? w_haz_new : r_haz;
  always_comb begin
    w_next = r_state == IDLE   ? (w_accept ? SETUP : IDLE) :
             r_state == SETUP  ? (r_load ? STROBE : HOLD) :
             r_state == STROBE ? (r_cnt == CNT_W'(LOAD_CYC - 1) ? HOLD : STROBE) : IDLE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_oe_vec <= '1;
      r_ld_vec <= '1;
      r_load   <= 1'b0;
      r_haz    <= 1'b0;
      r_err    <= 1'b0;
      r_oes    <= '1;
      r_lds    <= '1;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cnt   <= r_state == STROBE ? r_cnt + 1'b1 : '0;
      r_oes   <= (w_next == IDLE || (w_next == STROBE && w_haz_sel)) ? '1 : w_oe_sel;
      r_lds   <= w_next == STROBE ? w_ld_sel : '1;
      r_done  <= w_next == HOLD;
      r_ready <= w_next == IDLE;
      if (w_accept) begin
        r_oe_vec <= w_oe_dec;
        r_ld_vec <= w_ld_dec;
        r_load   <= load;
        r_haz    <= w_haz_new;
        r_err    <= w_oe_oor || w_ld_oor || (oe && !w_oe_src_ok) || (load && !w_ld_src_ok);
      end
    end
  end
  assign ready       = r_ready;
  assign regNotOEs   = r_oes;
  assign regNotLoads = r_lds;
  assign done        = r_done;
  assign selError    = r_err;
  assign hazard      = r_haz;
endmodule

// File: tb/tb_regsel_seq.sv
// tb_regsel_seq: two regsel_seq configurations against a queue-based per-request timeline model.
module tb_regsel_seq;
  logic clk = 1'b0, rst, start, oe, load, chk_en = 1'b0;
  logic [1:0] os, ls;
  logic [2:0] uo, ul;
  logic [8:0] ops;
  logic [7:0] oes0, lds0;
  logic [5:0] oes1, lds1;
  logic done0, rdy0, err0, haz0, done1, rdy1, err1, haz1;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  regsel_seq u0 (
    .clock(clk), .reset(rst), .start(start), .ready(rdy0), .oe(oe), .load(load),
    .oeSourceSel(os), .loadSourceSel(ls), .useqRegSelOE(uo), .useqRegSelLoad(ul), .ops(ops),
    .regNotOEs(oes0), .regNotLoads(lds0), .done(done0), .selError(err0), .hazard(haz0)
  );
  regsel_seq #(.NREGS(6), .LOAD_CYC(3)) u1 (
    .clock(clk), .reset(rst), .start(start), .ready(rdy1), .oe(oe), .load(load),
    .oeSourceSel(os), .loadSourceSel(ls), .useqRegSelOE(uo), .useqRegSelLoad(ul), .ops(ops),
    .regNotOEs(oes1), .regNotLoads(lds1), .done(done1), .selError(err1), .hazard(haz1)
  );
  typedef struct packed {logic [7:0] oes, lds; logic done, ready, err, haz;} rec_t;
  typedef struct {
    logic oe, ld; logic [1:0] os, ls; logic [2:0] uo, ul; logic [8:0] ops;
    logic [7:0] e_oe, e_ld; logic e_err1;
  } vec_t;
  rec_t q[2][$];
  rec_t cur[2];
  logic m_err[2], m_haz[2];
  int nregs[2] = '{8, 6};
  int lcyc[2]  = '{1, 3};
  vec_t tbl[9];
  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, a, e, $time);
    end
  endtask
  function automatic int pick(input logic [1:0] src, input logic [2:0] u);
    if (src == 2'd0) return int'(u);
    if (int'(src) > 3) return -1;
    return int'(ops[(int'(src) - 1) * 3 +: 3]);
  endfunction
  task automatic push_req(input int i);
    int oi, li;
    bit ov, lv, hz;
    logic [7:0] ovec, lvec;
    oi = pick(os, uo);
    li = pick(ls, ul);
    ov = oe && oi >= 0 && oi < nregs[i];
    lv = load && li >= 0 && li < nregs[i];
    ovec = 8'hFF;
    lvec = 8'hFF;
    if (ov) ovec[oi] = 1'b0;
    if (lv) lvec[li] = 1'b0;
    m_err[i] = (oe && !ov) || (load && !lv);
    hz = 1'b0;
`ifdef REGSEL_HAZARD_EN
    hz = ov && lv && oi == li;
`endif
    m_haz[i] = hz;
    q[i].push_back('{ovec, 8'hFF, 1'b0, 1'b0, m_err[i], hz});
    if (load) repeat (lcyc[i]) q[i].push_back('{hz ? 8'hFF : ovec, lvec, 1'b0, 1'b0, m_err[i], hz});
    q[i].push_back('{ovec, 8'hFF, 1'b1, 1'b0, m_err[i], hz});
  endtask
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        q[i].delete();
        m_err[i] = 1'b0;
        m_haz[i] = 1'b0;
        cur[i] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
      end else begin
        if (start && cur[i].ready) push_req(i);
        cur[i] = q[i].size() > 0 ? q[i].pop_front() : '{8'hFF, 8'hFF, 1'b0, 1'b1, m_err[i], m_haz[i]};
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      check("mon_u0", 32'({oes0, lds0, done0, rdy0, err0, haz0}), 32'(cur[0]));
      check("mon_u1", 32'({2'b11, oes1, 2'b11, lds1, done1, rdy1, err1, haz1}), 32'(cur[1]));
    end
  end
  task automatic wait_ready();
    int n = 0;
    while (!(rdy0 && rdy1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", 32'(rdy0 && rdy1), 32'd1);
  endtask
  task automatic issue(input vec_t v);
    wait_ready();
    oe = v.oe; load = v.ld; os = v.os; ls = v.ls; uo = v.uo; ul = v.ul; ops = v.ops;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; oe = 1'b0; load = 1'b0;
    os = '0; ls = '0; uo = '0; ul = '0; ops = '0;
    tbl[0] = '{1'b1, 1'b1, 2'd0, 2'd1, 3'd2, 3'd0, 9'o001, 8'hFB, 8'hFD, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 2'd1, 2'd0, 3'd0, 3'd0, 9'o731, 8'hFD, 8'hFF, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 2'd2, 2'd0, 3'd0, 3'd0, 9'o731, 8'hF7, 8'hFF, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 2'd3, 2'd0, 3'd0, 3'd0, 9'o731, 8'h7F, 8'hFF, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 2'd0, 2'd1, 3'd0, 3'd0, 9'o005, 8'hFF, 8'hDF, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 2'd0, 2'd0, 3'd6, 3'd0, 9'o000, 8'hBF, 8'hFF, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 9'o000, 8'hFE, 8'hFF, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 9'o000, 8'hFF, 8'hFF, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 2'd0, 2'd0, 3'd4, 3'd4, 9'o000, 8'hEF, 8'hEF, 1'b0};
    repeat (2) @(negedge clk);
    check("reset_oes", 32'(oes0), 32'hFF);
    check("reset_lds", 32'(lds0), 32'hFF);
    check("reset_ready", 32'({rdy0, done0, err0, haz0}), 32'b1000);
    rst = 1'b0;
    chk_en = 1'b1;
    for (int n = 0; n < 9; n++) begin
      logic hz;
      hz = 1'b0;
`ifdef REGSEL_HAZARD_EN
      hz = tbl[n].e_oe == tbl[n].e_ld && tbl[n].e_oe != 8'hFF;
`endif
      issue(tbl[n]);
      check("setup_oes", 32'(oes0), 32'(tbl[n].e_oe));
      check("setup_lds", 32'(lds0), 32'hFF);
      check("sel_error_u1", 32'(err1), 32'(tbl[n].e_err1));
      check("hazard", 32'(haz0), 32'(hz));
      if (tbl[n].ld) begin
        @(negedge clk);
        check("strobe_lds", 32'(lds0), 32'(tbl[n].e_ld));
        check("strobe_oes", 32'(oes0), 32'(hz ? 8'hFF : tbl[n].e_oe));
      end
    end
    begin
      int low = 0, dn = 0;
      issue(tbl[4]);
      for (int t = 1; t <= 7; t++) begin
        if (lds1 != 6'h3F) low++;
        if (done1) dn = t;
        @(negedge clk);
      end
      check("lcyc3_low_cycles", 32'(low), 32'd3);
      check("lcyc3_done_latency", 32'(dn), 32'd5);
    end
    issue(tbl[0]);
    start = 1'b1;
    oe = 1'b1; load = 1'b1; uo = 3'd7; ul = 3'd7; os = 2'd0; ls = 2'd0;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignored_lds", 32'(lds0), 32'hFD);
    #2 rst = 1'b1;
    #1;
    check("async_rst_u0", 32'({oes0, lds0, rdy0, done0}), 32'({8'hFF, 8'hFF, 1'b1, 1'b0}));
    check("async_rst_u1", 32'({oes1, lds1, rdy1, done1}), 32'({6'h3F, 6'h3F, 1'b1, 1'b0}));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    repeat (150) begin
      wait_ready();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      oe = 1'($urandom); load = 1'($urandom); os = 2'($urandom); ls = 2'($urandom);
      uo = 3'($urandom); ul = 3'($urandom); ops = 9'($urandom);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        oe = 1'($urandom); load = 1'($urandom); uo = 3'($urandom); ul = 3'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    wait_ready();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
